// File: rtl/nx1_tmode_pkg.sv
// Shared constants for the X1turbo/turboZ mode-register block: port indices,
// mode-register bit positions, default reset image and port capability helper.
package nx1_tmode_pkg;

  localparam int P1FD0 = 0;
  localparam int P1FE0 = 1;
  localparam int P1FF0 = 2;

  localparam int MAX_PORTS = 8;

  // 1FD0: display timing control
  localparam int FD0_BIT_HIRESO  = 0;
  localparam int FD0_BIT_LINE400 = 1;
  localparam int FD0_BIT_PCG     = 2;
  localparam int FD0_BIT_SCROLL  = 3;

  // 1FE0: palette / blackout control
  localparam int FE0_BIT_BLACK   = 0;
  localparam int FE0_BIT_PALSEL  = 1;

  localparam logic [MAX_PORTS*8-1:0] DEF_RST_VAL = '0;

  // Plain X1turbo only decodes 1FD0/1FE0; 1FF0 and above belong to turboZ.
  function automatic bit port_functional(input int mode, input int p);
    return !(mode == 1 && p >= P1FF0);
  endfunction

endpackage

// File: rtl/nx1_tmode_chan.sv
// One mode-register port: staging register, active register and pending flag,
// with an optional immediate path that skips vblank staging.
module nx1_tmode_chan #(
  parameter int              DW  = 8,
  parameter logic [DW-1:0]   RST = '0,
  parameter bit              IMM = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_i,
  input  logic [DW-1:0] d_i,
  input  logic          apply_i,
  output logic [DW-1:0] s_o,
  output logic [DW-1:0] a_o,
  output logic          p_o
);

  logic [DW-1:0] s_q, s_d;
  logic [DW-1:0] a_q, a_d;
  logic          p_q, p_d;

  always_comb begin
    s_d = s_q;
    a_d = a_q;
    p_d = 1'b0;
    if (wr_i) s_d = d_i;
    if (IMM) begin
      if (wr_i) a_d = d_i;
    end else begin
      // Apply uses the pre-edge staging value; a same-cycle write stays pending.
      if (apply_i && p_q) a_d = s_q;
      p_d = wr_i | (p_q & ~apply_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= RST;
      a_q <= RST;
      p_q <= 1'b0;
    end else begin
      s_q <= s_d;
      a_q <= a_d;
      p_q <= p_d;
    end
  end

  assign s_o = s_q;
  assign a_o = a_q;
  assign p_o = p_q;

endmodule

// File: rtl/nx1_tmode_vsync.sv
// X1turbo mode registers with vblank-synchronised apply: port decode,
// vblank edge detect, apply pulse and CPU readback mux.
module nx1_tmode_vsync
  import nx1_tmode_pkg::*;
#(
  parameter int                        def_X1TURBO = 1,
  parameter int                        NUM_PORTS   = 3,
  parameter int                        DW          = 8,
  parameter logic [NUM_PORTS*DW-1:0]   RST_VAL     = DEF_RST_VAL[NUM_PORTS*DW-1:0],
  parameter logic [NUM_PORTS-1:0]      IMM_MASK    = '0,
  parameter logic [NUM_PORTS-1:0]      RD_MASK     = '1
) (
  input  logic                      CLK,
  input  logic                      I_RESET_N,
  input  logic [7:0]                I_D,
  input  logic                      I_WR,
  input  logic                      I_RD,
  input  logic [NUM_PORTS-1:0]      I_CS,
  input  logic                      I_VBLANK,
  output logic [7:0]                O_D,
  output logic                      O_DOE,
  output logic [NUM_PORTS*DW-1:0]   O_MODE,
  output logic [NUM_PORTS-1:0]      O_PENDING,
  output logic                      O_APPLY
);

  localparam bit TURBO = (def_X1TURBO != 0);

  logic                    vblank_q, apply_q, apply_d;
  logic                    apply, onehot;
  logic [NUM_PORTS-1:0]    wr, pend, func_mask;
  logic [DW-1:0]           s_arr [NUM_PORTS];
  logic [DW-1:0]           a_arr [NUM_PORTS];
  logic [NUM_PORTS*DW-1:0] mode_w;
  logic [DW-1:0]           rd_sel;

  assign onehot = (|I_CS) && ((I_CS & (I_CS - NUM_PORTS'(1))) == '0);
  assign apply  = I_VBLANK & ~vblank_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      localparam bit FUNC = port_functional(def_X1TURBO, gi);
      assign func_mask[gi] = FUNC;
      assign wr[gi]        = I_WR & I_CS[gi] & onehot & FUNC;

      nx1_tmode_chan #(
        .DW  (DW),
        .RST (RST_VAL[gi*DW +: DW]),
        .IMM (IMM_MASK[gi])
      ) u_chan (
        .clk_i   (CLK),
        .rst_ni  (I_RESET_N),
        .wr_i    (wr[gi]),
        .d_i     (I_D[DW-1:0]),
        .apply_i (apply),
        .s_o     (s_arr[gi]),
        .a_o     (a_arr[gi]),
        .p_o     (pend[gi])
      );

      assign mode_w[gi*DW +: DW] = a_arr[gi];
    end
  endgenerate

  assign apply_d = apply & (|pend);

  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      vblank_q <= 1'b0;
      apply_q  <= 1'b0;
    end else begin
      vblank_q <= I_VBLANK;
      apply_q  <= apply_d;
    end
  end

  // Non-functional ports contribute nothing, so they read back as zero.
  always_comb begin
    rd_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (I_CS[p] && func_mask[p]) rd_sel = rd_sel | s_arr[p];
    end
  end

  assign O_DOE     = TURBO & I_RD & onehot & (|(I_CS & RD_MASK));
  assign O_D       = O_DOE ? 8'(rd_sel) : 8'h00;
  assign O_MODE    = TURBO ? mode_w : '0;
  assign O_PENDING = TURBO ? pend : '0;
  assign O_APPLY   = TURBO ? apply_q : 1'b0;

endmodule

// File: tb/tb_nx1_tmode_vsync.sv
// Self-checking bench for nx1_tmode_vsync: default, immediate-port and plain-X1
// instances share one stimulus stream; reads are checked through a scoreboard queue.
module tb_nx1_tmode_vsync;

  localparam int NP = 3;

  logic          CLK = 1'b0;
  logic          I_RESET_N;
  logic [7:0]    I_D;
  logic          I_WR, I_RD, I_VBLANK;
  logic [NP-1:0] I_CS;

  logic [7:0]      od_d, od_i, od_x;
  logic            doe_d, doe_i, doe_x;
  logic [NP*8-1:0] mode_d, mode_i, mode_x;
  logic [NP-1:0]   pend_d, pend_i, pend_x;
  logic            apply_d, apply_i, apply_x;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd_exp_q [$];
  logic [7:0] last_v [2];

  always #5 CLK = ~CLK;

  nx1_tmode_vsync dut (
    .CLK(CLK), .I_RESET_N(I_RESET_N), .I_D(I_D), .I_WR(I_WR), .I_RD(I_RD),
    .I_CS(I_CS), .I_VBLANK(I_VBLANK), .O_D(od_d), .O_DOE(doe_d),
    .O_MODE(mode_d), .O_PENDING(pend_d), .O_APPLY(apply_d)
  );

  nx1_tmode_vsync #(.IMM_MASK(3'b010)) dut_imm (
    .CLK(CLK), .I_RESET_N(I_RESET_N), .I_D(I_D), .I_WR(I_WR), .I_RD(I_RD),
    .I_CS(I_CS), .I_VBLANK(I_VBLANK), .O_D(od_i), .O_DOE(doe_i),
    .O_MODE(mode_i), .O_PENDING(pend_i), .O_APPLY(apply_i)
  );

  nx1_tmode_vsync #(.def_X1TURBO(0)) dut_x1 (
    .CLK(CLK), .I_RESET_N(I_RESET_N), .I_D(I_D), .I_WR(I_WR), .I_RD(I_RD),
    .I_CS(I_CS), .I_VBLANK(I_VBLANK), .O_D(od_x), .O_DOE(doe_x),
    .O_MODE(mode_x), .O_PENDING(pend_x), .O_APPLY(apply_x)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_port(input int p, input logic [7:0] v, input int cycles);
    I_CS = NP'(1 << p);
    I_D  = v;
    I_WR = 1'b1;
    for (int c = 0; c < cycles; c++) tick();
    I_WR = 1'b0;
    I_CS = '0;
    $display("write port=%0d data=%02h cycles=%0d", p, v, cycles);
  endtask

  task automatic read_check(input int p, input logic [7:0] exp, input string nm);
    logic [7:0] e;
    rd_exp_q.push_back(exp);
    I_CS = NP'(1 << p);
    I_RD = 1'b1;
    #2;
    e = rd_exp_q.pop_front();
    checks++;
    if (od_d !== e) begin
      errors++;
      $display("FAIL %s: O_D=%02h expected %02h", nm, od_d, e);
    end
    checks++;
    if (doe_d !== 1'b1) begin
      errors++;
      $display("FAIL %s_doe: O_DOE=%b expected 1", nm, doe_d);
    end
    $display("read port=%0d data=%02h exp=%02h", p, od_d, e);
    I_RD = 1'b0;
    I_CS = '0;
  endtask

  task automatic vblank_rise();
    I_VBLANK = 1'b1;
    tick();
    I_VBLANK = 1'b0;
  endtask

  task automatic test_reset();
    I_RESET_N = 1'b0;
    I_D = '0; I_WR = 1'b0; I_RD = 1'b0; I_CS = '0; I_VBLANK = 1'b0;
    #3;
    checks++;
    if (mode_d !== '0 || pend_d !== '0 || apply_d !== 1'b0 || doe_d !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mode=%h pend=%b apply=%b doe=%b expected 0/0/0/0",
               mode_d, pend_d, apply_d, doe_d);
    end
    #9;
    I_RESET_N = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_stage_apply();
    write_port(0, 8'h5A, 1);
    read_check(0, 8'h5A, "stage_read");
    checks++;
    if (mode_d[7:0] !== 8'h00 || pend_d[0] !== 1'b1) begin
      errors++;
      $display("FAIL stage_hold: mode0=%02h pend0=%b expected 00/1", mode_d[7:0], pend_d[0]);
    end
    vblank_rise();
    checks++;
    if (mode_d[7:0] !== 8'h5A || apply_d !== 1'b1 || pend_d[0] !== 1'b0) begin
      errors++;
      $display("FAIL stage_apply: mode0=%02h apply=%b pend0=%b expected 5a/1/0",
               mode_d[7:0], apply_d, pend_d[0]);
    end
    tick();
    checks++;
    if (apply_d !== 1'b0) begin
      errors++;
      $display("FAIL apply_pulse_width: O_APPLY=%b expected 0", apply_d);
    end
  endtask

  task automatic test_write_during_apply();
    write_port(1, 8'h11, 1);
    I_CS = 3'b010; I_D = 8'h22; I_WR = 1'b1; I_VBLANK = 1'b1;
    tick();
    I_WR = 1'b0; I_CS = '0; I_VBLANK = 1'b0;
    checks++;
    if (mode_d[15:8] !== 8'h11 || pend_d[1] !== 1'b1 || apply_d !== 1'b1) begin
      errors++;
      $display("FAIL wr_in_apply: mode1=%02h pend1=%b apply=%b expected 11/1/1",
               mode_d[15:8], pend_d[1], apply_d);
    end
    tick();
    read_check(1, 8'h22, "wr_in_apply_read");
    vblank_rise();
    checks++;
    if (mode_d[15:8] !== 8'h22 || pend_d[1] !== 1'b0) begin
      errors++;
      $display("FAIL wr_in_apply_next: mode1=%02h pend1=%b expected 22/0", mode_d[15:8], pend_d[1]);
    end
    tick();
  endtask

  task automatic test_immediate();
    write_port(1, 8'h7F, 1);
    checks++;
    if (mode_i[15:8] !== 8'h7F || pend_i[1] !== 1'b0 || apply_i !== 1'b0) begin
      errors++;
      $display("FAIL imm_write: mode1=%02h pend1=%b apply=%b expected 7f/0/0",
               mode_i[15:8], pend_i[1], apply_i);
    end
    checks++;
    if (mode_d[15:8] !== 8'h22 || pend_d[1] !== 1'b1) begin
      errors++;
      $display("FAIL imm_staged_peer: mode1=%02h pend1=%b expected 22/1", mode_d[15:8], pend_d[1]);
    end
    vblank_rise();
    checks++;
    if (apply_i !== 1'b0 || apply_d !== 1'b1 || mode_d[15:8] !== 8'h7F) begin
      errors++;
      $display("FAIL imm_vblank: apply_imm=%b apply=%b mode1=%02h expected 0/1/7f",
               apply_i, apply_d, mode_d[15:8]);
    end
    tick();
  endtask

  task automatic test_async_reset();
    write_port(0, 8'hFF, 1);
    checks++;
    if (pend_d[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_prestage: pend0=%b expected 1", pend_d[0]);
    end
    #3;
    I_RESET_N = 1'b0;
    #1;
    checks++;
    if (mode_d !== '0 || pend_d !== '0 || apply_d !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mode=%h pend=%b apply=%b expected 0/0/0", mode_d, pend_d, apply_d);
    end
    read_check(0, 8'h00, "reset_read");
    I_RESET_N = 1'b1;
    tick();
    vblank_rise();
    checks++;
    if (mode_d[7:0] !== 8'h00 || apply_d !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_vblank: mode0=%02h apply=%b expected 00/0", mode_d[7:0], apply_d);
    end
    tick();
  endtask

  task automatic test_x1_mode();
    for (int p = 0; p < NP; p++) write_port(p, 8'hFF, 1);
    I_CS = 3'b001; I_RD = 1'b1;
    #2;
    checks++;
    if (doe_x !== 1'b0 || od_x !== 8'h00 || pend_x !== '0) begin
      errors++;
      $display("FAIL x1_read: doe=%b od=%02h pend=%b expected 0/00/0", doe_x, od_x, pend_x);
    end
    I_CS = 3'b100;
    #1;
    checks++;
    if (od_d !== 8'h00) begin
      errors++;
      $display("FAIL turbo_port2_read: O_D=%02h expected 00", od_d);
    end
    I_RD = 1'b0; I_CS = '0;
    vblank_rise();
    checks++;
    if (mode_x !== '0 || apply_x !== 1'b0) begin
      errors++;
      $display("FAIL x1_vblank: mode=%h apply=%b expected 0/0", mode_x, apply_x);
    end
    checks++;
    if (mode_d !== 24'h00FFFF || pend_d !== '0 || apply_d !== 1'b1) begin
      errors++;
      $display("FAIL turbo_port_limit: mode=%h pend=%b apply=%b expected 00ffff/0/1",
               mode_d, pend_d, apply_d);
    end
    tick();
  endtask

  task automatic test_bad_cs();
    I_CS = 3'b011; I_D = 8'hAA; I_WR = 1'b1; I_RD = 1'b1;
    #2;
    checks++;
    if (doe_d !== 1'b0 || od_d !== 8'h00) begin
      errors++;
      $display("FAIL bad_cs_read: doe=%b od=%02h expected 0/00", doe_d, od_d);
    end
    tick();
    I_WR = 1'b0; I_RD = 1'b0; I_CS = '0;
    checks++;
    if (pend_d !== '0) begin
      errors++;
      $display("FAIL bad_cs_pend: pend=%b expected 000", pend_d);
    end
    read_check(0, 8'hFF, "bad_cs_p0");
    read_check(1, 8'hFF, "bad_cs_p1");
  endtask

  task automatic test_back_to_back();
    last_v[0] = 8'hFF;
    last_v[1] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      int p;
      logic [7:0] v;
      p = i % 2;
      v = 8'($urandom_range(0, 255));
      last_v[p] = v;
      write_port(p, v, 1 + (i % 3));
      read_check(p, v, "b2b_read");
    end
    checks++;
    if (pend_d[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL b2b_pend: pend=%b expected x11", pend_d);
    end
    vblank_rise();
    checks++;
    if (mode_d[15:0] !== {last_v[1], last_v[0]} || apply_d !== 1'b1) begin
      errors++;
      $display("FAIL b2b_apply: mode=%04h apply=%b expected %02h%02h/1",
               mode_d[15:0], apply_d, last_v[1], last_v[0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_stage_apply();
    test_write_during_apply();
    test_immediate();
    test_async_reset();
    test_x1_mode();
    test_bad_cs();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
